image_stream_loader: RTL and testbench

Streaming front end for the LeNet accelerator. It accepts one signed pixel per handshake, assembles a 28x28 frame in row-major order, and presents the frame as a parallel array on the accelerator's image input. It then counts the accelerator's fixed pipeline latency and pulses `result_valid` in the exact cycle the accelerator's `output_vector` holds the result for that frame.

---
 rtl/lenet_pkg.sv | 22 ++
 rtl/image_stream_loader_if.sv | 26 ++
 rtl/pixel_addr_counter.sv | 29 ++
 rtl/image_stream_loader.sv | 150 +++++++++++++++
 tb/tb_image_stream_loader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared types and frame geometry for the LeNet image stream loader.
package lenet_pkg;

    localparam int top_bitwidth = 9;
    localparam int IMG_DIM      = 28;
    localparam int PIX_COUNT    = IMG_DIM * IMG_DIM;
    localparam int ADDR_W       = $clog2(IMG_DIM);

    typedef logic signed [top_bitwidth-1:0] pixel_t;
    typedef pixel_t [IMG_DIM-1:0][IMG_DIM-1:0] frame_t;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

    function automatic logic is_last_addr(input logic [ADDR_W-1:0] row,
                                          input logic [ADDR_W-1:0] col);
        return (row == ADDR_W'(IMG_DIM - 1)) && (col == ADDR_W'(IMG_DIM - 1));
    endfunction

endpackage

// File: rtl/image_stream_loader_if.sv
// Pixel stream in, parallel frame and result strobe out.
interface image_stream_loader_if;
    import lenet_pkg::*;

    // A pixel transfers on any rising edge where pix_valid && pix_ready; the
    // source must hold pix_in/pix_last stable until that edge.
    pixel_t pix_in;
    logic   pix_valid;
    logic   pix_last;
    logic   pix_ready;
    frame_t image;
    logic   image_valid;
    logic   result_valid;
    logic   frame_err;

    modport master (
        output pix_in, pix_valid, pix_last,
        input  pix_ready, image, image_valid, result_valid, frame_err
    );

    modport slave (
        input  pix_in, pix_valid, pix_last,
        output pix_ready, image, image_valid, result_valid, frame_err
    );

endinterface

// File: rtl/pixel_addr_counter.sv
// Row-major row/col write pointer; wrap flags the last pixel of a frame.
module pixel_addr_counter
    import lenet_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              wrap
);

    assign wrap = is_last_addr(row, col);

    always_ff @(posedge clk) begin
        if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == ADDR_W'(IMG_DIM - 1)) begin
                col <= '0;
                row <= wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_stream_loader.sv
// Assembles a 28x28 frame from a pixel stream and times the accelerator result.
// Optional IMG_LOADER_PINGPONG_EN: double-buffered frames so loading overlaps HOLD.
module image_stream_loader
    import lenet_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    image_stream_loader_if.slave  bus,
    output loader_state_t         state_dbg
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  hold_cnt;
    logic [ADDR_W-1:0] row, col;
    logic              last_addr;
    logic              pix_ready_c;
    logic              accept;
    logic              frame_done;
    logic              hold_done;
    logic              load_hold;
    logic              result_valid_q;
    logic              frame_err_q;

    pixel_addr_counter u_addr (
        .clk  (clk),
        .clr  (!reset_n),
        .en   (accept),
        .row  (row),
        .col  (col),
        .wrap (last_addr)
    );

`ifdef IMG_LOADER_PINGPONG_EN
    frame_t bank_q [2];
    logic   disp_sel;
    logic   fill_full;
    logic   swap;

    // The fill bank keeps accepting during HOLD until it holds a whole frame.
    assign pix_ready_c = (state_q == LOAD) || !fill_full;
`else
    frame_t frame_q;

    assign pix_ready_c = (state_q == LOAD);
`endif

    assign accept     = bus.pix_valid && pix_ready_c;
    assign frame_done = accept && last_addr;
    assign hold_done  = (state_q == HOLD) && (hold_cnt == CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        load_hold = 1'b0;
`ifdef IMG_LOADER_PINGPONG_EN
        swap      = 1'b0;
`endif
        case (state_q)
            LOAD: begin
                if (frame_done) begin
                    state_d   = HOLD;
                    load_hold = 1'b1;
`ifdef IMG_LOADER_PINGPONG_EN
                    swap      = 1'b1;
`endif
                end
            end
            HOLD: begin
                if (hold_done) begin
`ifdef IMG_LOADER_PINGPONG_EN
                    // A ready fill bank goes straight to display without leaving HOLD.
                    if (fill_full || frame_done) begin
                        load_hold = 1'b1;
                        swap      = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= LOAD;
            hold_cnt       <= '0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_valid_q <= hold_done;
            if (load_hold) begin
                hold_cnt <= CNT_W'(HOLD_CYCLES);
            end else if (state_q == HOLD) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            // pix_last must coincide exactly with the counter's last address.
            if (accept && (bus.pix_last != last_addr)) begin
                frame_err_q <= 1'b1;
            end
        end
    end

`ifdef IMG_LOADER_PINGPONG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            disp_sel  <= 1'b0;
            fill_full <= 1'b0;
        end else begin
            if (accept) begin
                bank_q[!disp_sel][row][col] <= bus.pix_in;
            end
            if (swap) begin
                disp_sel  <= !disp_sel;
                fill_full <= 1'b0;
            end else if (frame_done) begin
                fill_full <= 1'b1;
            end
        end
    end

    assign bus.image = bank_q[disp_sel];
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_q <= '0;
        end else if (accept) begin
            frame_q[row][col] <= bus.pix_in;
        end
    end

    assign bus.image = frame_q;
`endif

    assign bus.pix_ready    = pix_ready_c;
    assign bus.image_valid  = (state_q == HOLD);
    assign bus.result_valid = result_valid_q;
    assign bus.frame_err    = frame_err_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Self-checking bench for image_stream_loader: frame vectors, reset and timing corners.
module tb_image_stream_loader;
  import lenet_pkg::*;

  typedef struct {
    int gap;        // 0 continuous valid, 1 every other cycle, 2 random
    int last_at;    // pixel index carrying pix_last
    bit rand_data;
    bit exp_err;    // frame_err expected after the frame
  } vec_t;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset_n;
  loader_state_t state_dbg, state_dbg1;

  image_stream_loader_if bus();
  image_stream_loader_if bus1();

  image_stream_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  image_stream_loader #(.HOLD_CYCLES(1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus1),
    .state_dbg (state_dbg1)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;
  int rv_total = 0;
  logic [top_bitwidth-1:0] exp_q[$];
  vec_t vecs[5];

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.result_valid === 1'b1) rv_total++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [top_bitwidth-1:0] pix_val(input int idx, input bit rnd);
    int v;
    if (rnd) return top_bitwidth'($urandom_range(0, 511));
    v = (idx % 256) - 128;
    return top_bitwidth'(v);
  endfunction

  // Drives up to n pixels; every accepted pixel is pushed to the scoreboard.
  task automatic feed(input vec_t v, input int n, output int accepted);
    int cyc;
    int not_rdy;
    bit vld;
    bit acc;
    logic [top_bitwidth-1:0] d;
    cyc = 0;
    not_rdy = 0;
    accepted = 0;
    d = pix_val(0, v.rand_data);
    while (accepted < n && cyc < 4000) begin
      case (v.gap)
        0: vld = 1'b1;
        1: vld = (cyc % 2 == 0);
        default: vld = 1'($urandom_range(0, 1));
      endcase
      bus.pix_valid = vld;
      bus.pix_in = d;
      bus.pix_last = (accepted == v.last_at);
      if (bus.pix_ready !== 1'b1) not_rdy++;
      acc = vld && (bus.pix_ready === 1'b1);
      if (acc) exp_q.push_back(d);
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (accepted == v.last_at && accepted != PIX_COUNT - 1)
          check("err_after_early_last", int'(bus.frame_err), 1);
        accepted++;
        d = pix_val(accepted, v.rand_data);
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_last = 1'b0;
    check("ready_in_load", not_rdy, 0);
  endtask

  task automatic run_frame(input vec_t v, input int vi);
    int acc_n;
    int mism;
    int iv_cnt;
    int rdy_hold;
    int rv_cnt;
    int rv_at;
    int exp_rdy;
    frame_t snap;
    logic [top_bitwidth-1:0] e;
    feed(v, PIX_COUNT, acc_n);
    check($sformatf("v%0d_accepts", vi), acc_n, PIX_COUNT);
    check($sformatf("v%0d_sb_size", vi), exp_q.size(), PIX_COUNT);
    mism = 0;
    for (int r = 0; r < IMG_DIM; r++) begin
      for (int c = 0; c < IMG_DIM; c++) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (bus.image[r][c] !== e) mism++;
        end
      end
    end
    exp_q.delete();
    check($sformatf("v%0d_frame_data", vi), mism, 0);
    snap = bus.image;
    iv_cnt = 0;
    rdy_hold = 0;
    rv_cnt = 0;
    rv_at = -1;
    for (int c = 0; c <= HOLD + 1; c++) begin
`ifdef IMG_LOADER_PINGPONG_EN
      bus.pix_valid = 1'b0;
`else
      bus.pix_valid = (c < HOLD);
`endif
      if (bus.image_valid === 1'b1) iv_cnt++;
      if (c < HOLD && bus.pix_ready === 1'b1) rdy_hold++;
      if (bus.result_valid === 1'b1) begin
        rv_cnt++;
        rv_at = c;
      end
      if (c == HOLD - 1) check($sformatf("v%0d_img_stable", vi), int'(bus.image === snap), 1);
      if (c == HOLD) check($sformatf("v%0d_end_iv_rdy", vi), int'({bus.image_valid, bus.pix_ready}), 1);
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
`ifdef IMG_LOADER_PINGPONG_EN
    exp_rdy = HOLD;
`else
    exp_rdy = 0;
`endif
    check($sformatf("v%0d_iv_cycles", vi), iv_cnt, HOLD);
    check($sformatf("v%0d_rv_count", vi), rv_cnt, 1);
    check($sformatf("v%0d_rv_cycle", vi), rv_at, HOLD);
    check($sformatf("v%0d_ready_in_hold", vi), rdy_hold, exp_rdy);
    check($sformatf("v%0d_frame_err", vi), int'(bus.frame_err), int'(v.exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n;
    int rv_snap;
    int iv;
    int rv_at;

    vecs[0] = '{gap: 0, last_at: 783, rand_data: 1'b0, exp_err: 1'b0};
    vecs[1] = '{gap: 1, last_at: 783, rand_data: 1'b0, exp_err: 1'b0};
    vecs[2] = '{gap: 2, last_at: 783, rand_data: 1'b1, exp_err: 1'b0};
    vecs[3] = '{gap: 0, last_at: 500, rand_data: 1'b1, exp_err: 1'b1};
    vecs[4] = '{gap: 2, last_at: 783, rand_data: 1'b1, exp_err: 1'b1};

    reset_n = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in = '0;
    bus.pix_last = 1'b0;
    bus1.pix_valid = 1'b0;
    bus1.pix_in = '0;
    bus1.pix_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.pix_ready), 1);
    check("rst_image_valid", int'(bus.image_valid), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    check("rst_state", int'(state_dbg), int'(LOAD));
    check("rst_img_27_27", int'($signed(bus.image[27][27])), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], i);
      if (i == 0) begin
        check("v0_img_0_0", int'($signed(bus.image[0][0])), -128);
        check("v0_img_27_27", int'($signed(bus.image[27][27])), -113);
      end
    end

    // Reset while pixel 300 is next: partial frame dropped, sticky error cleared.
    feed(vecs[0], 300, acc_n);
    exp_q.delete();
    check("partial_accepts", acc_n, 300);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_img_0_0", int'($signed(bus.image[0][0])), 0);
    check("mid_img_5_10", int'($signed(bus.image[5][10])), 0);
    check("mid_frame_err", int'(bus.frame_err), 0);
    check("mid_ready", int'(bus.pix_ready), 1);
    reset_n = 1'b1;
    run_frame(vecs[0], 5);
    check("post_rst_img_0_0", int'($signed(bus.image[0][0])), -128);

    // Reset during HOLD: no result pulse for the aborted frame.
    rv_snap = rv_total;
    feed(vecs[0], PIX_COUNT, acc_n);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("hold_abort_iv", int'(bus.image_valid), 0);
    repeat (HOLD + 2) @(posedge clk);
    #1;
    check("hold_abort_rv", rv_total - rv_snap, 0);
    check("rv_total", rv_total, 6);

    // HOLD_CYCLES = 1 instance.
    check("h1_ready", int'(bus1.pix_ready), 1);
    for (int i = 0; i < PIX_COUNT; i++) begin
      bus1.pix_valid = 1'b1;
      bus1.pix_in = pix_val(i, 1'b0);
      bus1.pix_last = (i == PIX_COUNT - 1);
      @(posedge clk); #1;
    end
    bus1.pix_valid = 1'b0;
    bus1.pix_last = 1'b0;
    iv = 0;
    rv_at = -1;
    for (int c = 0; c < 4; c++) begin
      if (bus1.image_valid === 1'b1) iv++;
      if (bus1.result_valid === 1'b1 && rv_at < 0) rv_at = c;
      @(posedge clk); #1;
    end
    check("h1_iv_cycles", iv, 1);
    check("h1_rv_cycle", rv_at, 1);
    check("h1_img_27_27", int'($signed(bus1.image[27][27])), -113);
    check("h1_frame_err", int'(bus1.frame_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
